cpu_output_fifo: RTL

- Output buffer directly downstream of the pipelined CPU.
- Captures the CPU result word on every cycle the CPU raises its output flag, and queues it in a first-word-fall-through FIFO.
- Drains the queue to an external consumer over a valid/ready handshake.
- Reports occupancy, raises a near-full backpressure hint the CPU hazard logic can use as a stall source, and records dropped words.

---
 rtl/cpu_output_pkg.sv | 26 ++
 rtl/fifo_storage.sv | 34 +++
 rtl/cpu_output_fifo.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_output_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_output_pkg
// Brief    : Shared constants, count type and saturating helper for the
//            CPU output FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_output_pkg;

    localparam int OUT_WIDTH  = 16;
    localparam int OUT_DEPTH  = 8;
    localparam int DROP_WIDTH = 8;

    typedef logic [$clog2(OUT_DEPTH):0] count_t;

    // Increments value, holding at the all-ones value of a width-bit counter.
    function automatic logic [31:0] satInc(input logic [31:0] value, input int width);
        logic [31:0] maxVal;
        maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= maxVal) ? maxVal : (value + 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_storage.sv
//------------------------------------------------------------------------------
// Module   : fifo_storage
// Brief    : DEPTH x WIDTH register array, one synchronous write port and one
//            asynchronous read port; no reset on the contents.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_storage #(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 8,
    localparam int PTRWIDTH = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                we,
    input  logic [PTRWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [PTRWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]    rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/cpu_output_fifo.sv
//------------------------------------------------------------------------------
// Module   : cpu_output_fifo
// Brief    : First-word-fall-through buffer between the CPU result strobe and a
//            valid/ready consumer, with occupancy, near-full hint and drop log.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_output_fifo
    import cpu_output_pkg::*;
#(
    parameter  int WIDTH     = OUT_WIDTH,
    parameter  int DEPTH     = OUT_DEPTH,
    parameter  int DROPWIDTH = DROP_WIDTH,
    localparam int PTRWIDTH  = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 outFlag,
    input  logic [WIDTH-1:0]     out,
    output logic [WIDTH-1:0]     dataOut,
    output logic                 dataValid,
    input  logic                 dataReady,
    output logic [PTRWIDTH:0]    count,
    output logic                 full,
    output logic                 almostFull,
    output logic                 overflow,
    output logic [DROPWIDTH-1:0] dropCount,
    input  logic                 clearOverflow
);

    localparam logic [PTRWIDTH:0]    c_COUNT_FULL   = (PTRWIDTH+1)'(DEPTH);
    localparam logic [PTRWIDTH:0]    c_COUNT_ALMOST = (PTRWIDTH+1)'(DEPTH - 1);
    localparam logic [PTRWIDTH:0]    c_COUNT_ONE    = (PTRWIDTH+1)'(1);
    localparam logic [PTRWIDTH-1:0]  c_PTR_ONE      = PTRWIDTH'(1);
    localparam logic [DROPWIDTH-1:0] c_DROP_ONE     = DROPWIDTH'(1);

    logic [PTRWIDTH-1:0]  r_wrPtr;
    logic [PTRWIDTH-1:0]  r_rdPtr;
    logic [PTRWIDTH:0]    r_count;
    logic                 r_overflow;
    logic [DROPWIDTH-1:0] r_dropCount;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_pushAccept;
    logic                 w_drop;
    logic [WIDTH-1:0]     w_rdata;
    logic [DROPWIDTH-1:0] w_dropNext;

    // Status comes only from the registered count, keeping outFlag/dataReady
    // off any combinational path to the flags.
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_COUNT_FULL);
    assign w_pop        = !w_empty && dataReady;
    assign w_pushAccept = outFlag && (!w_full || w_pop);
    assign w_drop       = outFlag && w_full && !w_pop;
    assign w_dropNext   = DROPWIDTH'(satInc(32'(r_dropCount), DROPWIDTH));

    fifo_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clock (clock),
        .we    (w_pushAccept),
        .waddr (r_wrPtr),
        .wdata (out),
        .raddr (r_rdPtr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushAccept) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
            if (w_pushAccept && !w_pop) begin
                r_count <= r_count + c_COUNT_ONE;
            end else if (w_pop && !w_pushAccept) begin
                r_count <= r_count - c_COUNT_ONE;
            end
        end
    end

    // A drop in the same cycle as a clear is counted after the clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_dropCount <= '0;
        end else if (clearOverflow) begin
            r_overflow  <= w_drop;
            r_dropCount <= w_drop ? c_DROP_ONE : '0;
        end else if (w_drop) begin
            r_overflow  <= 1'b1;
            r_dropCount <= w_dropNext;
        end
    end

    // Storage is never reset, so the head word is masked while empty.
    assign dataOut    = w_empty ? '0 : w_rdata;
    assign dataValid  = !w_empty;
    assign count      = r_count;
    assign full       = w_full;
    assign almostFull = (r_count >= c_COUNT_ALMOST);
    assign overflow   = r_overflow;
    assign dropCount  = r_dropCount;

endmodule

`default_nettype wire
